// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: steps one instruction through fetch/decode/execute/memory/writeback
// and drives the datapath selects and strobes from registered outputs.
module multicycle_controller #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt, next_cnt;
    logic            running;
    logic            supported;
    logic [2:0]      func_alu;
    logic [2:0]      imm_sel;
    logic            unused_func7;

    logic            pc_write_q, adr_src_q, mem_write_q, ir_write_q, reg_write_q;
    logic [1:0]      result_src_q, alu_src_a_q, alu_src_b_q;
    logic [2:0]      alu_control_q;
    logic            pc_write_d, adr_src_d, mem_write_d, ir_write_d, reg_write_d;
    logic [1:0]      result_src_d, alu_src_a_d, alu_src_b_d;
    logic [2:0]      alu_control_d;

    assign supported = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                       (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        func_alu = 3'b000;
        case (func3)
            3'b000:  func_alu = (op == OP_R && func7[5]) ? 3'b001 : 3'b000;
            3'b010:  func_alu = 3'b101;
            3'b110:  func_alu = 3'b011;
            3'b111:  func_alu = 3'b010;
            default: func_alu = 3'b000;
        endcase
    end

    always_comb begin
        imm_sel = 3'b000;
        case (op)
            OP_SW:   imm_sel = 3'b001;
            OP_BEQ:  imm_sel = 3'b010;
            OP_JAL:  imm_sel = 3'b011;
            default: imm_sel = 3'b000;
        endcase
    end

    // The wait counter only counts inside FETCH/MEMREAD and stops at LAST, so it never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = '0;
        case (state)
            FETCH:    if (cnt == LAST) next_state = DECODE;
                      else next_cnt = cnt + CW'(1);
            DECODE:   begin
                          case (op)
                              OP_LW, OP_SW: next_state = MEMADR;
                              OP_R:         next_state = EXECR;
                              OP_I:         next_state = EXECI;
                              OP_BEQ:       next_state = BEQ;
                              OP_JAL:       next_state = JAL;
                              default:      next_state = FETCH;
                          endcase
                      end
            MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  if (cnt == LAST) next_state = MEMWB;
                      else next_cnt = cnt + CW'(1);
            EXECR, EXECI, JAL: next_state = ALUWB;
            default:  next_state = FETCH;
        endcase
        // First edge after reset release only restarts FETCH, so no strobe lands on it.
        if (!running) begin
            next_state = FETCH;
            next_cnt   = '0;
        end
    end

    always_comb begin
        pc_write_d    = 1'b0;
        adr_src_d     = 1'b0;
        mem_write_d   = 1'b0;
        ir_write_d    = 1'b0;
        reg_write_d   = 1'b0;
        result_src_d  = 2'b00;
        alu_src_a_d   = 2'b00;
        alu_src_b_d   = 2'b00;
        alu_control_d = 3'b000;
        case (next_state)
            FETCH:    begin
                          alu_src_b_d  = 2'b10;
                          result_src_d = 2'b10;
                          ir_write_d   = (next_cnt == LAST);
                          pc_write_d   = (next_cnt == LAST);
                      end
            DECODE:   begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
            MEMADR:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
            MEMREAD:  adr_src_d = 1'b1;
            MEMWB:    begin result_src_d = 2'b01; reg_write_d = 1'b1; end
            MEMWRITE: begin adr_src_d = 1'b1; mem_write_d = 1'b1; end
            EXECR:    begin alu_src_a_d = 2'b10; alu_control_d = func_alu; end
            EXECI:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; alu_control_d = func_alu; end
            ALUWB:    reg_write_d = 1'b1;
            BEQ:      begin alu_src_a_d = 2'b10; alu_control_d = 3'b001; end
            JAL:      begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; pc_write_d = 1'b1; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            cnt           <= '0;
            running       <= 1'b0;
            pc_write_q    <= 1'b0;
            adr_src_q     <= 1'b0;
            mem_write_q   <= 1'b0;
            ir_write_q    <= 1'b0;
            reg_write_q   <= 1'b0;
            result_src_q  <= 2'b00;
            alu_src_a_q   <= 2'b00;
            alu_src_b_q   <= 2'b00;
            alu_control_q <= 3'b000;
        end else begin
            state         <= next_state;
            cnt           <= next_cnt;
            running       <= 1'b1;
            pc_write_q    <= pc_write_d;
            adr_src_q     <= adr_src_d;
            mem_write_q   <= mem_write_d;
            ir_write_q    <= ir_write_d;
            reg_write_q   <= reg_write_d;
            result_src_q  <= result_src_d;
            alu_src_a_q   <= alu_src_a_d;
            alu_src_b_q   <= alu_src_b_d;
            alu_control_q <= alu_control_d;
        end
    end

    // Branch decision and IR-derived outputs must follow the live inputs, not last edge's.
    assign PCWrite    = pc_write_q | ((state == BEQ) & Zero);
    assign Illegal    = (state == DECODE) & ~supported;
    assign ImmSrc     = rst ? 3'b000 : imm_sel;
    assign AdrSrc     = adr_src_q;
    assign MemWrite   = mem_write_q;
    assign IRWrite    = ir_write_q;
    assign RegWrite   = reg_write_q;
    assign ResultSrc  = result_src_q;
    assign ALUSrcA    = alu_src_a_q;
    assign ALUSrcB    = alu_src_b_q;
    assign ALUControl = alu_control_q;

endmodule
